// File: rtl/data_ram.sv
// Single-port MEM-stage data memory: byte/halfword/word accesses with byte-lane
// writes, sign/zero-extended registered loads and selectable write-port read behaviour.
module data_ram #(
  parameter int    ADDR_BITS = 10,
  parameter int    READ_MODE = 0,
  parameter string INIT_FILE = "memfile.tv"
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ram_ena,
  input  logic                 wena,
  input  logic [1:0]           size,
  input  logic                 sign_ext,
  input  logic [ADDR_BITS+1:0] addr,
  input  logic [31:0]          data_in,
  output logic [31:0]          data_out,
  output logic                 rd_valid,
  output logic                 addr_err
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [31:0]          mem_q [DEPTH];
  logic [ADDR_BITS-1:0] idx_s;
  logic [1:0]           off_s;
  logic                 legal_s;
  logic [3:0]           be_s;
  logic [31:0]          wdata_s;
  logic                 wr_en_s;
  logic [31:0]          data_out_q;
  logic                 rd_valid_q;
  logic                 addr_err_q;

  // Extract the addressed lanes, right-align them and extend to 32 bits.
  function automatic logic [31:0] fmt(input logic [31:0] word, input logic [1:0] off,
                                      input logic [1:0] sz, input logic sx);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (sz)
      2'b00:   fmt = {{24{sx & sh[7]}}, sh[7:0]};
      2'b01:   fmt = {{16{sx & sh[15]}}, sh[15:0]};
      default: fmt = sh;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    for (int k = 0; k < 4; k++) begin
      merge[8*k +: 8] = be[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
    end
  endfunction

  // Decode alignment, byte enables and lane-replicated store data.
  always_comb begin
    idx_s   = addr[ADDR_BITS+1:2];
    off_s   = addr[1:0];
    legal_s = 1'b0;
    be_s    = 4'b0000;
    wdata_s = data_in;
    case (size)
      2'b00: begin
        legal_s = 1'b1;
        be_s    = 4'b0001 << off_s;
        wdata_s = {4{data_in[7:0]}};
      end
      2'b01: begin
        legal_s = ~addr[0];
        be_s    = off_s[1] ? 4'b1100 : 4'b0011;
        wdata_s = {2{data_in[15:0]}};
      end
      2'b10: begin
        legal_s = (off_s == 2'b00);
        be_s    = 4'b1111;
        wdata_s = data_in;
      end
      default: begin
        legal_s = 1'b0;
        be_s    = 4'b0000;
        wdata_s = data_in;
      end
    endcase
    wr_en_s = ram_ena & wena & legal_s & ~rst;
  end

  // Byte-lane write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int k = 0; k < 4; k++) begin
        if (be_s[k]) begin
          mem_q[idx_s][8*k +: 8] <= wdata_s[8*k +: 8];
        end
      end
    end
  end

  // Registered read port with valid/error strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_q <= 32'h0;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else if (ram_ena) begin
      if (!legal_s) begin
        rd_valid_q <= 1'b0;
        addr_err_q <= 1'b1;
      end else if (!wena) begin
        data_out_q <= fmt(mem_q[idx_s], off_s, size, sign_ext);
        rd_valid_q <= 1'b1;
        addr_err_q <= 1'b0;
      end else if (READ_MODE == 2) begin
        rd_valid_q <= 1'b0;
        addr_err_q <= 1'b0;
      end else begin
        // Write-first returns the merged word the write port is about to commit.
        data_out_q <= fmt((READ_MODE == 1) ? merge(mem_q[idx_s], wdata_s, be_s) : mem_q[idx_s],
                          off_s, size, sign_ext);
        rd_valid_q <= 1'b1;
        addr_err_q <= 1'b0;
      end
    end else begin
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign addr_err = addr_err_q;

endmodule
